music_sequencer: RTL and testbench
==================================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL provide parameter SEQ_LEN, default 16, meaning the number of notes in the sequence (2..256).
REQ-002 SHALL provide parameter NOTE_W, default 18, meaning the bit width of one note's half-period count.
REQ-003 SHALL provide parameter NOTE_ROM, default all-zero, SEQ_LEN*NOTE_W bits, meaning the note table; entry i occupies bits [i*NOTE_W +: NOTE_W], and value 0 means rest.
REQ-004 SHALL provide parameter BEAT_CYCLES, default 12_500_000, meaning the PLAY length in clock cycles at mode 0.
REQ-005 SHALL provide parameter GAP_CYCLES, default 1_000_000, meaning the length of the silence between notes in cycles (>=1).
REQ-006 SHALL have port CLK100MHZ, input, 1 bit: the single clock; all logic is on its rising edge and no derived clocks are used.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port music_enable, input, 1 bit: high to play, low to pause.
REQ-009 SHALL have port mode, input, 2 bits: tempo select, where beat length = BEAT_CYCLES << mode.
REQ-010 SHALL have port AUD_PWM, output, 1 bit: square-wave speaker drive.
REQ-011 SHALL have port AUD_SD, output, 1 bit: amplifier enable, high while not IDLE.
REQ-012 SHALL have port note_idx, output, clog2(SEQ_LEN) bits: index of the current note.
REQ-013 SHALL have port playing, output, 1 bit: high in state PLAY only.

Function
REQ-014 SHALL implement an FSM with states IDLE, PLAY and GAP.
REQ-015 SHALL move IDLE->PLAY on the first cycle with music_enable=1; on entry tone_cnt=0, beat_cnt=0, AUD_PWM=0, and mode is latched into mode_q.
REQ-016 SHALL, in PLAY with half=NOTE_ROM[note_idx]!=0, increment tone_cnt each cycle; when tone_cnt==half-1, AUD_PWM toggles and tone_cnt clears, so the first rising edge occurs after half PLAY cycles.
REQ-017 SHALL hold AUD_PWM at 0 for the whole PLAY interval when half==0 (rest).
REQ-018 SHALL keep PLAY for exactly (BEAT_CYCLES<<mode_q) cycles, then enter GAP with AUD_PWM=0.
REQ-019 SHALL keep GAP for exactly GAP_CYCLES cycles with AUD_PWM=0, then advance note_idx, re-latch mode and enter PLAY.
REQ-020 SHALL wrap note_idx from SEQ_LEN-1 to 0 and loop the sequence indefinitely.
REQ-021 SHALL treat a mode change outside a latch point (REQ-015, REQ-019) as having no effect on the current note.
REQ-022 SHALL, when music_enable=0 in PLAY or GAP, enter IDLE next cycle, force AUD_PWM=0, clear counters and hold note_idx (pause).
REQ-023 SHALL, on resume from pause, replay the note at the held note_idx from its start.
REQ-024 SHALL size the beat counter to hold (BEAT_CYCLES<<3)-1 without overflow, and the tone counter to NOTE_W bits.
REQ-025 SHALL let disable take priority when music_enable falls on the same cycle as a PLAY->GAP or GAP->PLAY boundary: the result is IDLE, and note_idx advances only if the GAP end coincides.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, force state=IDLE, note_idx=0, AUD_PWM=0, AUD_SD=0, playing=0 and all counters 0, regardless of music_enable.
REQ-027 SHALL give rst priority over all other inputs, including mid-PLAY; the first note after reset is index 0.

Verification
(Bench parameters: SEQ_LEN=4, NOTE_W=8, NOTE_ROM={0,5,3,2} as entries 3..0, BEAT_CYCLES=20, GAP_CYCLES=4.)
REQ-028 SHALL cover playback: rst, then enable with mode=0 -> AUD_PWM toggles every 2 cycles for 20 cycles (5 periods), then is low for 4 cycles, then note_idx=1.
REQ-029 SHALL cover rest handling: let playback reach idx 3 -> AUD_PWM stays 0 for the 20-cycle PLAY with playing=1, then note_idx wraps to 0.
REQ-030 SHALL cover the tempo latch: mode=2 -> PLAY lasts 80 cycles; changing mode to 0 mid-note keeps 80 cycles, and the next note lasts 20.
REQ-031 SHALL cover pause/resume: drop enable at cycle 10 of idx 1 -> IDLE next cycle with AUD_PWM=0 and AUD_SD=0, note_idx=1 held; re-enable -> idx 1 replays for a full 20 cycles.
REQ-032 SHALL cover reset mid-note: assert rst during idx 2 PLAY -> all outputs 0 next cycle; after release with enable high, playback restarts at idx 0.
REQ-033 SHALL cover a simultaneous event: drop enable on the last GAP cycle -> IDLE, with note_idx advanced by exactly one.

Source files
------------

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - note-table square-wave sequencer with tempo select, rests and pause
module music_sequencer #(
    parameter int                          SEQ_LEN     = 16,
    parameter int                          NOTE_W      = 18,
    parameter logic [SEQ_LEN*NOTE_W-1:0]   NOTE_ROM    = '0,
    parameter int                          BEAT_CYCLES = 12_500_000,
    parameter int                          GAP_CYCLES  = 1_000_000
) (
    input  logic                        CLK100MHZ,
    input  logic                        rst,
    input  logic                        music_enable,
    input  logic [1:0]                  mode,
    output logic                        AUD_PWM,
    output logic                        AUD_SD,
    output logic [$clog2(SEQ_LEN)-1:0]  note_idx,
    output logic                        playing
);

    localparam int IDX_W  = $clog2(SEQ_LEN);
    // Wide enough for the slowest tempo: (BEAT_CYCLES << 3) - 1.
    localparam int BEAT_W = $clog2(BEAT_CYCLES * 8);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_BASE = BEAT_W'(BEAT_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_note_idx;
    logic [1:0]          r_mode_q;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [NOTE_W-1:0]   r_tone_cnt;
    logic                r_pwm;

    state_t              w_state_nx;
    logic [IDX_W-1:0]    w_idx_nx;
    logic [1:0]          w_mode_nx;
    logic [BEAT_W-1:0]   w_beat_nx;
    logic [GAP_W-1:0]    w_gap_nx;
    logic [NOTE_W-1:0]   w_tone_nx;
    logic                w_pwm_nx;

    logic [NOTE_W-1:0]   w_rom [SEQ_LEN];
    logic [NOTE_W-1:0]   w_half;
    logic [BEAT_W-1:0]   w_beat_last;
    logic [IDX_W-1:0]    w_idx_inc;

    // Unpack the flat note table into one entry per index.
    genvar gi;
    generate
        for (gi = 0; gi < SEQ_LEN; gi++) begin : g_rom
            assign w_rom[gi] = NOTE_ROM[gi*NOTE_W +: NOTE_W];
        end
    endgenerate

    assign w_half      = w_rom[r_note_idx];
    assign w_beat_last = (BEAT_BASE << r_mode_q) - BEAT_W'(1);
    assign w_idx_inc   = (r_note_idx == IDX_LAST) ? '0 : r_note_idx + 1'b1;

    // State and datapath registers; reset wins over everything, including mid-note.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_note_idx <= '0;
            r_mode_q   <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_tone_cnt <= '0;
            r_pwm      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_note_idx <= w_idx_nx;
            r_mode_q   <= w_mode_nx;
            r_beat_cnt <= w_beat_nx;
            r_gap_cnt  <= w_gap_nx;
            r_tone_cnt <= w_tone_nx;
            r_pwm      <= w_pwm_nx;
        end
    end

    // Next-state logic: counters and the speaker output fall back to zero unless
    // the current state is actively advancing them, so every exit is silent.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_note_idx;
        w_mode_nx  = r_mode_q;
        w_beat_nx  = '0;
        w_gap_nx   = '0;
        w_tone_nx  = '0;
        w_pwm_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (music_enable) begin
                    w_state_nx = S_PLAY;
                    w_mode_nx  = mode;
                end
            end
            S_PLAY: begin
                if (!music_enable) begin
                    w_state_nx = S_IDLE;
                end else if (r_beat_cnt == w_beat_last) begin
                    w_state_nx = S_GAP;
                end else begin
                    w_beat_nx = r_beat_cnt + 1'b1;
                    if (w_half != '0) begin
                        if (r_tone_cnt == w_half - 1'b1) begin
                            w_pwm_nx = ~r_pwm;
                        end else begin
                            w_pwm_nx  = r_pwm;
                            w_tone_nx = r_tone_cnt + 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    // The note still advances when disable lands on the final gap cycle.
                    w_idx_nx = w_idx_inc;
                    if (music_enable) begin
                        w_state_nx = S_PLAY;
                        w_mode_nx  = mode;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else if (!music_enable) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_gap_nx = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign AUD_PWM  = r_pwm;
    assign AUD_SD   = (r_state != S_IDLE);
    assign playing  = (r_state == S_PLAY);
    assign note_idx = r_note_idx;

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - scoreboard bench for music_sequencer against a behavioural model
module tb_music_sequencer;

    localparam int SEQ_LEN = 4;
    localparam int NOTE_W  = 8;
    localparam int BEAT    = 20;
    localparam int GAP     = 4;
    localparam logic [31:0] ROM = {8'd0, 8'd5, 8'd3, 8'd2};

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_GAP  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       pwm;
    logic       sd;
    logic       play;
    logic [1:0] idx;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position inside the song as (state, note, elapsed cycles).
    int note_half [SEQ_LEN] = '{2, 3, 5, 0};
    int m_st  = M_IDLE;
    int m_idx = 0;
    int m_k   = 0;
    int m_len = BEAT;
    logic       e_pwm;
    logic [4:0] exp_q [$];
    logic [4:0] mon_exp;

    always #5 clk = ~clk;

    music_sequencer #(
        .SEQ_LEN    (SEQ_LEN),
        .NOTE_W     (NOTE_W),
        .NOTE_ROM   (ROM),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .CLK100MHZ   (clk),
        .rst         (rst),
        .music_enable(en),
        .mode        (mode),
        .AUD_PWM     (pwm),
        .AUD_SD      (sd),
        .note_idx    (idx),
        .playing     (play)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // Model step on every edge; the expected outputs after this edge go to the scoreboard.
    always @(posedge clk) begin
        if (rst) begin
            m_st = M_IDLE; m_idx = 0; m_k = 0;
        end else begin
            case (m_st)
                M_IDLE: if (en) begin m_st = M_PLAY; m_k = 0; m_len = BEAT << mode; end
                M_PLAY: begin
                    if (!en) m_st = M_IDLE;
                    else if (m_k == m_len - 1) begin m_st = M_GAP; m_k = 0; end
                    else m_k++;
                end
                default: begin
                    if (m_k == GAP - 1) begin
                        m_idx = (m_idx + 1) % SEQ_LEN;
                        if (en) begin m_st = M_PLAY; m_k = 0; m_len = BEAT << mode; end
                        else m_st = M_IDLE;
                    end else if (!en) m_st = M_IDLE;
                    else m_k++;
                end
            endcase
        end
        e_pwm = 1'b0;
        if (m_st == M_PLAY && note_half[m_idx] != 0)
            e_pwm = ((m_k / note_half[m_idx]) % 2) == 1;
        exp_q.push_back({e_pwm, m_st != M_IDLE, m_st == M_PLAY, 2'(m_idx)});
    end

    // Monitor: the DUT presents a new output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("scoreboard{pwm,sd,playing,idx}", 32'({pwm, sd, play, idx}), 32'(mon_exp));
        end
    end

    task automatic wait_for(input int st, input int wi, input int wk, input string name);
        int n = 0;
        while (!(m_st == st && (wi < 0 || m_idx == wi) && (wk < 0 || m_k == wk)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 3000), 32'd1);
    endtask

    task automatic measure_play(input int chg_at, input logic [1:0] chg_mode, output int len);
        len = 0;
        while (play && len < 400) begin
            if (len == chg_at) mode = chg_mode;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_play(input string name);
        int n = 0;
        while (!play && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int len;
        int want;
        rst = 1'b1; en = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({pwm, sd, play, idx}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain playback through the whole table, including the rest and the wrap.
        en = 1'b1;
        repeat (100) @(negedge clk);

        // Tempo latch: mode 2 latched at a gap end, changed mid-note with no effect.
        wait_for(M_GAP, -1, GAP - 1, "tempo_sync_reached");
        mode = 2'd2;
        @(negedge clk);
        measure_play(30, 2'd0, len);
        check("tempo_mode2_play_len", 32'(len), 32'd80);
        wait_play("tempo_next_note_started");
        measure_play(-1, 2'd0, len);
        check("tempo_next_play_len", 32'(len), 32'd20);

        // Pause on cycle 10 of note 1, then resume from its start.
        wait_for(M_PLAY, 1, 9, "pause_sync_reached");
        en = 1'b0;
        @(negedge clk);
        check("pause_sd", 32'(sd), 32'd0);
        check("pause_pwm", 32'(pwm), 32'd0);
        check("pause_playing", 32'(play), 32'd0);
        check("pause_idx_held", 32'(idx), 32'd1);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("resume_idx", 32'(idx), 32'd1);
        measure_play(-1, 2'd0, len);
        check("resume_play_len", 32'(len), 32'd20);

        // Disable on the final gap cycle: idle, yet the note advances.
        wait_for(M_GAP, -1, GAP - 1, "gapend_sync_reached");
        want = (m_idx + 1) % SEQ_LEN;
        en = 1'b0;
        @(negedge clk);
        check("gapend_idx_advanced", 32'(idx), 32'(want));
        check("gapend_sd", 32'(sd), 32'd0);
        en = 1'b1;
        repeat (10) @(negedge clk);

        // Reset in the middle of note 2 with enable held high.
        wait_for(M_PLAY, 2, 5, "rst_sync_reached");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 32'({pwm, sd, play, idx}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_idx0_playing", 32'({play, idx}), 32'b100);
        repeat (30) @(negedge clk);

        // Randomised enable bursts, tempo changes and the odd reset.
        for (int s = 0; s < 20; s++) begin
            mode = 2'($urandom_range(0, 3));
            en = 1'b1;
            rst = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < int'($urandom_range(1, 60)); c++) begin
                if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            en = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
